lcd_scanout: RTL and testbench



---
 rtl/lcd_scanout.sv | 161 ++++++++++++++++
 tb/tb_lcd_scanout.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_scanout.sv
// lcd_scanout: scans the 640x64 Z88 image out of nibble-wide VRAM onto a
// 640x480 raster. Each Z88 line is shown four times inside a vertical window;
// the rest of the active area is border. Everything advances on pce ticks.
module lcd_scanout #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_START  = 112,
    parameter logic [11:0] INK      = 12'h0F0,
    parameter logic [11:0] PAPER    = 12'h020,
    parameter logic [11:0] BORDER   = 12'h000
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic        pce,
    input  logic        lcdon,
    output logic [13:0] vram_ra,
    input  logic [3:0]  vram_rd,
    output logic [11:0] rgb,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic        sof
);
    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] HActive   = 10'(H_ACTIVE);
    localparam logic [9:0] HLast     = 10'(HTotal - 1);
    // Group 0 of the next line is fetched four pixels before the line wraps.
    localparam logic [9:0] HPrefetch = 10'(HTotal - 4);
    // Groups 1.. are fetched one group ahead; the last issue is at H_ACTIVE-8.
    localparam logic [9:0] HIssueEnd = 10'(H_ACTIVE - 4);
    localparam logic [9:0] HSyncBeg  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VActive   = 10'(V_ACTIVE);
    localparam logic [9:0] VLast     = 10'(VTotal - 1);
    localparam logic [9:0] VSyncBeg  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd  = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] VWinBeg   = 10'(V_START);
    localparam logic [9:0] VWinEnd   = 10'(V_START + 256);

    logic [9:0]  r_h, r_v;
    logic [13:0] r_ra;
    logic [3:0]  r_nxt, r_shift;
    logic [11:0] r_rgb;
    logic        r_hsync_n, r_vsync_n, r_de, r_sof;

    logic [9:0]  w_h_next, w_v_next, w_v_plus1;
    logic        w_active, w_window, w_hsync_n, w_vsync_n;
    logic        w_prefetch, w_issue, w_tgt_in_win, w_pixel;
    logic [9:0]  w_tgt_line, w_tgt_off;
    logic [5:0]  w_zline;
    logic [7:0]  w_group;
    logic [13:0] w_ra;
    logic [11:0] w_rgb;

    // Raster position arithmetic and region decode for the current (h,v).
    always_comb begin
        w_v_plus1 = (r_v == VLast) ? 10'd0 : r_v + 10'd1;
        w_h_next  = (r_h == HLast) ? 10'd0 : r_h + 10'd1;
        w_v_next  = (r_h == HLast) ? w_v_plus1 : r_v;
        w_active  = (r_h < HActive) && (r_v < VActive);
        w_window  = w_active && (r_v >= VWinBeg) && (r_v < VWinEnd);
        w_hsync_n = !((r_h >= HSyncBeg) && (r_h < HSyncEnd));
        w_vsync_n = !((r_v >= VSyncBeg) && (r_v < VSyncEnd));
    end

    // Fetch address: one group ahead of display, next line's group 0 at the wrap.
    always_comb begin
        w_prefetch    = (r_h == HPrefetch);
        w_tgt_line    = w_prefetch ? w_v_plus1 : r_v;
        w_tgt_off     = w_tgt_line - VWinBeg;
        w_zline       = w_tgt_off[7:2];
        w_group       = w_prefetch ? 8'd0 : r_h[9:2] + 8'd1;
        w_tgt_in_win  = (w_tgt_line >= VWinBeg) && (w_tgt_line < VWinEnd);
        w_issue       = (w_prefetch || ((r_h[1:0] == 2'b00) && (r_h < HIssueEnd)))
                        && w_tgt_in_win;
        // zline*160 as shift-and-add
        w_ra          = {1'b0, w_zline, 7'b0} + {3'b0, w_zline, 5'b0} + {6'b0, w_group};
    end

    // Pixel bit and colour priority: blank, border, LCD off, ink/paper.
    always_comb begin
        w_pixel = (r_h[1:0] == 2'b00) ? r_nxt[3] : r_shift[2];
        if (!w_active) begin
            w_rgb = 12'h000;
        end else if (!w_window) begin
            w_rgb = BORDER;
        end else if (!lcdon) begin
            w_rgb = PAPER;
        end else begin
            w_rgb = w_pixel ? INK : PAPER;
        end
    end

    // Raster counters advance once per pce tick.
    always_ff @(posedge mck) begin
        if (!rin_n) begin
            r_h <= 10'd0;
            r_v <= 10'd0;
        end else if (pce) begin
            r_h <= w_h_next;
            r_v <= w_v_next;
        end
    end

    // Registered video outputs for the pre-increment position; sof lasts one mck.
    always_ff @(posedge mck) begin
        if (!rin_n) begin
            r_rgb     <= 12'h000;
            r_de      <= 1'b0;
            r_hsync_n <= 1'b1;
            r_vsync_n <= 1'b1;
            r_sof     <= 1'b0;
        end else begin
            r_sof <= 1'b0;
            if (pce) begin
                r_rgb     <= w_rgb;
                r_de      <= w_active;
                r_hsync_n <= w_hsync_n;
                r_vsync_n <= w_vsync_n;
                r_sof     <= (r_h == 10'd0) && (r_v == 10'd0);
            end
        end
    end

    // Fetch pipeline: issue address, capture nibble, load/shift pixel register.
    always_ff @(posedge mck) begin
        if (!rin_n) begin
            r_ra    <= 14'd0;
            r_nxt   <= 4'd0;
            r_shift <= 4'd0;
        end else if (pce) begin
            if (w_issue) begin
                r_ra <= w_ra;
            end
            if (r_h[1:0] == 2'b01) begin
                r_nxt <= vram_rd;
            end
            if (r_h[1:0] == 2'b00) begin
                r_shift <= r_nxt;
            end else begin
                r_shift <= {r_shift[2:0], 1'b0};
            end
        end
    end

    assign vram_ra = r_ra;
    assign rgb     = r_rgb;
    assign hsync_n = r_hsync_n;
    assign vsync_n = r_vsync_n;
    assign de      = r_de;
    assign sof     = r_sof;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout on a reduced raster (32-pixel lines, short blanking)
// so a whole frame plus a mid-frame reset fits in a short run. The reference
// model derives every output from the tick count with plain div/mod arithmetic.
module tb_lcd_scanout;
    localparam int HA = 32, HFP = 4, HSW = 8, HBP = 4, HT = HA + HFP + HSW + HBP;
    localparam int VA = 264, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
    localparam int VST = 4;
    localparam int FRAME = HT * VT;
    localparam logic [11:0] INK = 12'h0F0, PAPER = 12'h020, BORDER = 12'h000;

    logic        mck = 1'b0;
    logic        rin_n, pce, lcdon;
    logic [13:0] vram_ra;
    logic [3:0]  vram_rd;
    logic [11:0] rgb;
    logic        hsync_n, vsync_n, de, sof;

    logic [3:0]  vram_mem [16384];
    logic [11:0] rows [8][HA];

    int checks = 0;
    int errors = 0;
    int n;
    int cur_h, cur_v;
    logic [11:0] exp_rgb;
    logic        exp_de, exp_hs, exp_vs, exp_sof, idle_sof;
    logic [13:0] exp_ra;
    int sof_cnt, sof_first, sof_second, hs_start, hs_len, vs_start, vs_len;
    logic [13:0] ra_first, ra_g1, ra_lastg, ra_l4, ra_end, ra_lcdoff, ra_mid;

    lcd_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .V_START(VST), .INK(INK), .PAPER(PAPER), .BORDER(BORDER)
    ) dut (
        .mck(mck), .rin_n(rin_n), .pce(pce), .lcdon(lcdon),
        .vram_ra(vram_ra), .vram_rd(vram_rd), .rgb(rgb),
        .hsync_n(hsync_n), .vsync_n(vsync_n), .de(de), .sof(sof)
    );

    always #5 mck = ~mck;

    // VRAM model: data follows the address one mck later
    always @(posedge mck) vram_rd <= vram_mem[vram_ra];

    function automatic logic in_win_line(int v);
        return (v >= VST) && (v < VST + 256) && (v < VA);
    endfunction

    function automatic logic [11:0] model_rgb(int h, int v, logic l);
        logic [3:0] w;
        if (!(h < HA && v < VA)) return 12'h000;
        if (!in_win_line(v)) return BORDER;
        if (!l) return PAPER;
        w = vram_mem[((v - VST) / 4) * 160 + h / 4];
        return w[3 - (h % 4)] ? INK : PAPER;
    endfunction

    // One idle mck, then one pce tick; computes expected outputs for that tick.
    task automatic pce_tick();
        int tv, g;
        logic hit;
        @(posedge mck); #1;
        idle_sof = sof;
        cur_h = n % HT;
        cur_v = (n / HT) % VT;
        exp_rgb = model_rgb(cur_h, cur_v, lcdon);
        exp_de  = (cur_h < HA) && (cur_v < VA);
        exp_hs  = !(cur_h >= HA + HFP && cur_h < HA + HFP + HSW);
        exp_vs  = !(cur_v >= VA + VFP && cur_v < VA + VFP + VSW);
        exp_sof = (cur_h == 0) && (cur_v == 0);
        hit = 1'b0;
        tv = 0;
        g = 0;
        if (cur_h % 4 == 0 && cur_h / 4 + 1 < HA / 4) begin
            tv = cur_v; g = cur_h / 4 + 1; hit = 1'b1;
        end else if (cur_h == HT - 4) begin
            tv = (cur_v + 1) % VT; g = 0; hit = 1'b1;
        end
        if (hit && in_win_line(tv)) exp_ra = 14'(((tv - VST) / 4) * 160 + g);
        pce = 1'b1;
        @(posedge mck); #1;
        pce = 1'b0;
        n++;
    endtask

    task automatic test_reset();
        rin_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pce = (i % 2 == 0);
            @(posedge mck); #1;
            checks++;
            if (rgb !== 12'h000 || de !== 1'b0 || hsync_n !== 1'b1 || vsync_n !== 1'b1 ||
                sof !== 1'b0 || vram_ra !== 14'd0) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got rgb=%h de=%b hs=%b vs=%b sof=%b ra=%0d, want 000 0 1 1 0 0",
                         i, rgb, de, hsync_n, vsync_n, sof, vram_ra);
            end
        end
        pce = 1'b0;
        rin_n = 1'b1;
        n = 0;
        exp_ra = 14'd0;
    endtask

    task automatic test_frame();
        int r;
        sof_cnt = 0; sof_first = -1; sof_second = -1;
        hs_start = -1; hs_len = 0; vs_start = -1; vs_len = 0;
        for (int i = 0; i <= FRAME; i++) begin
            if (n % HT == HA / 2 && (n / HT) % VT == 100) lcdon = 1'b0;
            if (n % HT == 0 && (n / HT) % VT == 101) lcdon = 1'b1;
            pce_tick();
            checks++;
            if (rgb !== exp_rgb) begin
                errors++;
                $display("FAIL frame_rgb (%0d,%0d): got %h want %h", cur_h, cur_v, rgb, exp_rgb);
            end
            checks++;
            if (de !== exp_de) begin
                errors++;
                $display("FAIL frame_de (%0d,%0d): got %b want %b", cur_h, cur_v, de, exp_de);
            end
            checks++;
            if (hsync_n !== exp_hs || vsync_n !== exp_vs) begin
                errors++;
                $display("FAIL frame_sync (%0d,%0d): got hs=%b vs=%b want hs=%b vs=%b",
                         cur_h, cur_v, hsync_n, vsync_n, exp_hs, exp_vs);
            end
            checks++;
            if (sof !== exp_sof || idle_sof !== 1'b0) begin
                errors++;
                $display("FAIL frame_sof (%0d,%0d): got %b idle %b want %b idle 0",
                         cur_h, cur_v, sof, idle_sof, exp_sof);
            end
            checks++;
            if (vram_ra !== exp_ra) begin
                errors++;
                $display("FAIL frame_ra (%0d,%0d): got %0d want %0d", cur_h, cur_v, vram_ra, exp_ra);
            end
            r = -1;
            if (cur_v == VST - 1) r = 0;
            else if (cur_v >= VST && cur_v <= VST + 4) r = cur_v - VST + 1;
            else if (cur_v == VST + 256) r = 6;
            else if (cur_v == 100) r = 7;
            if (r >= 0 && cur_h < HA) rows[r][cur_h] = rgb;
            if (sof === 1'b1) begin
                if (sof_cnt == 0) sof_first = n - 1; else sof_second = n - 1;
                sof_cnt++;
            end
            if (cur_v == 0 && hsync_n === 1'b0) begin
                if (hs_start < 0) hs_start = cur_h;
                hs_len++;
            end
            if (vsync_n === 1'b0) begin
                if (vs_start < 0) vs_start = cur_v;
                vs_len++;
            end
            if (cur_h == HT - 4 && cur_v == VST - 1) ra_first = vram_ra;
            if (cur_h == 0 && cur_v == VST) ra_g1 = vram_ra;
            if (cur_h == HA - 8 && cur_v == VST) ra_lastg = vram_ra;
            if (cur_h == HT - 4 && cur_v == VST + 3) ra_l4 = vram_ra;
            if (cur_h == HA - 8 && cur_v == VST + 255) ra_end = vram_ra;
            if (cur_h == HA - 8 && cur_v == 100) ra_lcdoff = vram_ra;
            if (errors > 50) break;
        end
    endtask

    task automatic test_syncs_sof();
        checks++;
        if (hs_start != HA + HFP || hs_len != HSW) begin
            errors++;
            $display("FAIL hsync_window: got start %0d len %0d want %0d %0d", hs_start, hs_len, HA + HFP, HSW);
        end
        checks++;
        if (vs_start != VA + VFP || vs_len != VSW * HT) begin
            errors++;
            $display("FAIL vsync_window: got line %0d ticks %0d want %0d %0d", vs_start, vs_len, VA + VFP, VSW * HT);
        end
        checks++;
        if (sof_cnt != 2 || sof_first != 0 || sof_second != FRAME) begin
            errors++;
            $display("FAIL sof_period: got cnt %0d at %0d,%0d want 2 at 0,%0d", sof_cnt, sof_first, sof_second, FRAME);
        end
    endtask

    task automatic test_address();
        checks++;
        if (ra_first !== 14'd0) begin
            errors++; $display("FAIL addr_prefetch: got %0d want 0", ra_first);
        end
        checks++;
        if (ra_g1 !== 14'd1) begin
            errors++; $display("FAIL addr_group1: got %0d want 1", ra_g1);
        end
        checks++;
        if (ra_lastg !== 14'(HA / 4 - 1)) begin
            errors++; $display("FAIL addr_lastgroup: got %0d want %0d", ra_lastg, HA / 4 - 1);
        end
        checks++;
        if (ra_l4 !== 14'd160) begin
            errors++; $display("FAIL addr_line_plus4: got %0d want 160", ra_l4);
        end
        checks++;
        if (ra_end !== 14'(63 * 160 + HA / 4 - 1)) begin
            errors++; $display("FAIL addr_last_line: got %0d want %0d", ra_end, 63 * 160 + HA / 4 - 1);
        end
    endtask

    task automatic test_pixel_order();
        logic [11:0] want [4];
        want[0] = INK; want[1] = PAPER; want[2] = INK; want[3] = PAPER;
        for (int x = 0; x < 4; x++) begin
            checks++;
            if (rows[1][x] !== want[x]) begin
                errors++;
                $display("FAIL pixel_order x%0d: got %h want %h", x, rows[1][x], want[x]);
            end
        end
    endtask

    task automatic test_line_repeat();
        logic bad, diff;
        for (int r = 2; r <= 4; r++) begin
            bad = 1'b0;
            for (int x = 0; x < HA; x++) if (rows[r][x] !== rows[1][x]) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL line_repeat row %0d: got differs want equal to line %0d", VST + r - 1, VST);
            end
        end
        diff = 1'b0;
        for (int x = 0; x < HA; x++) if (rows[5][x] !== rows[1][x]) diff = 1'b1;
        checks++;
        if (!diff) begin
            errors++; $display("FAIL line_next_zline: got equal want line %0d differs", VST + 4);
        end
        for (int r = 0; r <= 6; r += 6) begin
            bad = 1'b0;
            for (int x = 0; x < HA; x++) if (rows[r][x] !== BORDER) bad = 1'b1;
            checks++;
            if (bad) begin
                errors++; $display("FAIL border_row %0d: got non-border want %h", r, BORDER);
            end
        end
    endtask

    task automatic test_lcdon();
        logic bad;
        bad = 1'b0;
        for (int x = HA / 2; x < HA; x++) if (rows[7][x] !== PAPER) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++; $display("FAIL lcdon_paper: got non-paper pixel want %h", PAPER);
        end
        checks++;
        if (ra_lcdoff !== 14'(24 * 160 + HA / 4 - 1)) begin
            errors++; $display("FAIL lcdon_fetch: got %0d want %0d", ra_lcdoff, 24 * 160 + HA / 4 - 1);
        end
    endtask

    task automatic test_reset_mid();
        while (n % FRAME != 150 * HT + 21) pce_tick();
        @(posedge mck); #1;
        rin_n = 1'b0;
        pce = 1'b1;
        @(posedge mck); #1;
        rin_n = 1'b1;
        pce = 1'b0;
        checks++;
        if (rgb !== 12'h000 || de !== 1'b0 || hsync_n !== 1'b1 || vsync_n !== 1'b1 ||
            sof !== 1'b0 || vram_ra !== 14'd0) begin
            errors++;
            $display("FAIL midreset_state: got rgb=%h de=%b hs=%b vs=%b sof=%b ra=%0d, want 000 0 1 1 0 0",
                     rgb, de, hsync_n, vsync_n, sof, vram_ra);
        end
        n = 0;
        exp_ra = 14'd0;
        pce_tick();
        checks++;
        if (sof !== 1'b1 || rgb !== 12'h000 || hsync_n !== 1'b1 || vsync_n !== 1'b1 || vram_ra !== 14'd0) begin
            errors++;
            $display("FAIL midreset_first_tick: got sof=%b rgb=%h hs=%b vs=%b ra=%0d want 1 000 1 1 0",
                     sof, rgb, hsync_n, vsync_n, vram_ra);
        end
        for (int i = 1; i < 5 * HT; i++) begin
            pce_tick();
            checks++;
            if (rgb !== exp_rgb || de !== exp_de || hsync_n !== exp_hs || vsync_n !== exp_vs ||
                sof !== exp_sof || vram_ra !== exp_ra) begin
                errors++;
                $display("FAIL midreset_run (%0d,%0d): got %h %b %b %b %b %0d want %h %b %b %b %b %0d",
                         cur_h, cur_v, rgb, de, hsync_n, vsync_n, sof, vram_ra,
                         exp_rgb, exp_de, exp_hs, exp_vs, exp_sof, exp_ra);
            end
            if (cur_h == 0 && cur_v == VST) ra_mid = vram_ra;
            if (errors > 50) break;
        end
        checks++;
        if (ra_mid !== 14'd1) begin
            errors++; $display("FAIL midreset_addr: got %0d want 1", ra_mid);
        end
    endtask

    initial begin
        pce = 1'b0;
        lcdon = 1'b1;
        rin_n = 1'b0;
        ra_mid = 14'd0;
        for (int i = 0; i < 16384; i++) vram_mem[i] = 4'($urandom);
        vram_mem[0]   = 4'b1010;
        vram_mem[160] = 4'b0101;
        test_reset();
        test_frame();
        test_syncs_sof();
        test_address();
        test_pixel_order();
        test_line_repeat();
        test_lcdon();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
